serial_paralelo_align: RTL

- Parametrised successor to the fixed 8-bit serial-to-parallel converter in the PCIe-style PHY receive path, clocked at clk_32f.
- Assembles MSB-first serial bits into WIDTH-bit words and substitutes the COMMA idle symbol for bit slots where valid is low.
- Locks after LOCK_COUNT consecutive commas, then forwards data words to the clk_4f-side consumer.
- New relative to the predecessor: optional bit-level comma alignment, configurable lock threshold, a resync request, and a comma strobe.

---
 rtl/sp_pkg.sv | 14 +
 rtl/sp_shift_word.sv | 43 ++++
 rtl/serial_paralelo_align.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sp_pkg.sv
// Shared types and defaults for the serial-to-parallel aligner.
// The SP_BIT_ALIGN_EN macro (see serial_paralelo_align) does not affect this file.
package sp_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2
    } sp_state_t;

    localparam logic [7:0] DEF_COMMA      = 8'hBC;
    localparam int         DEF_LOCK_COUNT = 4;

endpackage

// File: rtl/sp_shift_word.sv
// Serial shift register and free-running bit counter with idle-slot COMMA substitution.
// Emits the candidate word each cycle and flags the word boundary.
module sp_shift_word #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] COMMA = WIDTH'(sp_pkg::DEF_COMMA)
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             valid,
    input  logic             data_in,
    input  logic             align_clr,
    output logic [WIDTH-1:0] cand,
    output logic             boundary
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic             bit_in;

    // Idle slots take the COMMA bit for the current position so an idle lane reads as commas.
    assign bit_in   = valid ? data_in : COMMA[LAST - bit_cnt];
    assign cand     = {shreg[WIDTH-2:0], bit_in};
    assign boundary = (bit_cnt == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            shreg <= cand;
            if (align_clr || boundary) begin
                bit_cnt <= '0;
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_paralelo_align.sv
// Serial-to-parallel converter with comma lock, resync and comma strobe.
// Define SP_BIT_ALIGN_EN to search for commas at every bit offset while hunting.
module serial_paralelo_align
    import sp_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(DEF_COMMA),
    parameter int               LOCK_COUNT = DEF_LOCK_COUNT
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             valid,
    input  logic             data_in,
    input  logic             resync,
    output logic [WIDTH-1:0] word_raw,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active,
    output logic             comma_det
);

    localparam int LCW = $clog2(LOCK_COUNT + 1);

    sp_state_t        state_q, state_d;
    logic [LCW-1:0]   lock_q, lock_d;
    logic [WIDTH-1:0] cand;
    logic             boundary;
    logic             align_clr;
    logic             is_comma;
    logic             hunt_cmp;

    logic [WIDTH-1:0] word_raw_d, data_out_d;
    logic             valid_out_d, comma_det_d;

    sp_shift_word #(
        .WIDTH (WIDTH),
        .COMMA (COMMA)
    ) u_shift (
        .clk_32f   (clk_32f),
        .reset     (reset),
        .valid     (valid),
        .data_in   (data_in),
        .align_clr (align_clr),
        .cand      (cand),
        .boundary  (boundary)
    );

    assign is_comma = (cand == COMMA);
`ifdef SP_BIT_ALIGN_EN
    assign hunt_cmp = 1'b1;
`else
    assign hunt_cmp = boundary;
`endif

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state_q <= HUNT;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        lock_d    = lock_q;
        align_clr = 1'b0;
        if (resync) begin
            state_d = HUNT;
            lock_d  = '0;
        end else begin
            case (state_q)
                HUNT: begin
                    if (hunt_cmp && is_comma) begin
                        align_clr = 1'b1;
                        lock_d    = LCW'(1);
                        state_d   = (LOCK_COUNT == 1) ? ACTIVE : SYNC;
                    end
                end
                SYNC: begin
                    if (boundary) begin
                        if (is_comma) begin
                            if (int'(lock_q) < LOCK_COUNT) begin
                                lock_d = lock_q + 1'b1;
                            end
                            if (int'(lock_q) + 1 == LOCK_COUNT) begin
                                state_d = ACTIVE;
                            end
                        end else begin
                            lock_d  = '0;
                            state_d = HUNT;
                        end
                    end
                end
                ACTIVE:  state_d = ACTIVE;
                default: state_d = HUNT;
            endcase
        end
    end

    always_comb begin
        word_raw_d  = word_raw;
        data_out_d  = data_out;
        valid_out_d = valid_out;
        comma_det_d = 1'b0;
        if (resync) begin
            valid_out_d = 1'b0;
        end else begin
            if (boundary) begin
                word_raw_d = cand;
            end
            case (state_q)
                HUNT: begin
                    valid_out_d = 1'b0;
                    comma_det_d = hunt_cmp && is_comma;
                end
                SYNC: begin
                    valid_out_d = 1'b0;
                    comma_det_d = boundary && is_comma;
                end
                ACTIVE: begin
                    if (boundary) begin
                        if (is_comma) begin
                            comma_det_d = 1'b1;
                            valid_out_d = 1'b0;
                        end else begin
                            data_out_d  = cand;
                            valid_out_d = 1'b1;
                        end
                    end
                end
                default: valid_out_d = 1'b0;
            endcase
        end
    end

    // Word outputs only move at boundaries, so they stay stable for the clk_4f sampler.
    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            word_raw  <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            comma_det <= 1'b0;
        end else begin
            word_raw  <= word_raw_d;
            data_out  <= data_out_d;
            valid_out <= valid_out_d;
            comma_det <= comma_det_d;
        end
    end

    assign active = (state_q == ACTIVE);

endmodule
